// File: rtl/n64_vdemux_pkg.sv
// Shared video-bus parameters for the N64 capture front end: widths, sync nibble
// bit positions, default PAL threshold and the VD phase type.
package n64adv_vparams;

    localparam int color_width_i = 7;
    localparam int vdata_width   = 4 + 3 * color_width_i;

    // Bit positions inside the 4-bit sync nibble (MSB first on the output word)
    localparam int vdata_vs   = 3;
    localparam int vdata_clmp = 2;
    localparam int vdata_hs   = 1;
    localparam int vdata_cs   = 0;

    localparam logic [9:0] pal_thresh = 10'd288;
    localparam logic [3:0] sync_idle  = 4'hF;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_R    = 2'd1,
        PH_G    = 2'd2,
        PH_B    = 2'd3
    } phase_t;

endpackage

// File: rtl/n64_vdemux_vinfo.sv
// Per-frame video info: counts hsync falls between vsync falls on committed
// pixels and derives PAL / 480i flags plus a field toggle.
module n64_vinfo_ext #(
    parameter logic [9:0] pal_thresh = n64adv_vparams::pal_thresh
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sync_nib,
    input  logic       commit,
    output logic [1:0] vinfo,
    output logic       field
);
    import n64adv_vparams::*;

    logic [3:0] prev_sync_r;
    logic [9:0] line_cnt_r;
    logic       prev_lsb_r;
    logic       pal_r;
    logic       i480_r;
    logic       field_r;
    logic       hs_fall_s;
    logic       vs_fall_s;

    // Edges are only meaningful between two committed pixels
    always_comb begin
        hs_fall_s = commit & prev_sync_r[vdata_hs] & ~sync_nib[vdata_hs];
        vs_fall_s = commit & prev_sync_r[vdata_vs] & ~sync_nib[vdata_vs];
    end

    // Line counter, frame classification and field toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sync_r <= sync_idle;
            line_cnt_r  <= 10'd0;
            prev_lsb_r  <= 1'b0;
            pal_r       <= 1'b0;
            i480_r      <= 1'b0;
            field_r     <= 1'b0;
        end else begin
            if (commit) begin
                prev_sync_r <= sync_nib;
            end
            if (vs_fall_s) begin
                pal_r      <= (line_cnt_r > pal_thresh);
                i480_r     <= (line_cnt_r[0] != prev_lsb_r);
                prev_lsb_r <= line_cnt_r[0];
                field_r    <= ~field_r;
                // an hsync in the vsync pixel already counts as the first line
                line_cnt_r <= hs_fall_s ? 10'd1 : 10'd0;
            end else if (hs_fall_s && (line_cnt_r != 10'd1023)) begin
                line_cnt_r <= line_cnt_r + 10'd1;
            end
        end
    end

    assign vinfo = {pal_r, i480_r};
    assign field = field_r;

endmodule

// File: rtl/n64_vdemux.sv
// N64 VD bus demultiplexer: sync/R/G/B phases into one parallel word per pixel.
// Define N64_VDEMUX_VINFO_EN to compile in line counting, PAL/480i and field.
module n64_vdemux #(
    parameter int         color_width_i = n64adv_vparams::color_width_i,
    parameter logic [9:0] pal_thresh    = n64adv_vparams::pal_thresh
) (
    input  logic                         VCLK,
    input  logic                         VRST,
    input  logic                         nVDSYNC,
    input  logic [color_width_i-1:0]     VD_i,
    output logic                         vdata_valid_o,
    output logic [4+3*color_width_i-1:0] vdata_o,
    output logic [1:0]                   vinfo_o,
    output logic                         field_o
);
    import n64adv_vparams::*;

    phase_t                   ph_r;
    phase_t                   ph_nxt_s;
    logic                     cap_sync_s;
    logic                     cap_r_s;
    logic                     cap_g_s;
    logic                     cap_b_s;
    logic [3:0]               sync_r;
    logic [color_width_i-1:0] red_r;
    logic [color_width_i-1:0] grn_r;
    logic [color_width_i-1:0] blu_r;
    logic                     commit_r;

    // Phase state register
    always_ff @(posedge VCLK or posedge VRST) begin
        if (VRST) begin
            ph_r <= PH_IDLE;
        end else begin
            ph_r <= ph_nxt_s;
        end
    end

    // Next phase: a sync phase always restarts the pixel, aborting any partial one
    always_comb begin
        ph_nxt_s = ph_r;
        if (!nVDSYNC) begin
            ph_nxt_s = PH_R;
        end else begin
            case (ph_r)
                PH_R:    ph_nxt_s = PH_G;
                PH_G:    ph_nxt_s = PH_B;
                PH_B:    ph_nxt_s = PH_IDLE;
                default: ph_nxt_s = PH_IDLE;
            endcase
        end
    end

    // Capture enables decoded from the current phase
    always_comb begin
        cap_sync_s = 1'b0;
        cap_r_s    = 1'b0;
        cap_g_s    = 1'b0;
        cap_b_s    = 1'b0;
        if (!nVDSYNC) begin
            cap_sync_s = 1'b1;
        end else begin
            case (ph_r)
                PH_R:    cap_r_s = 1'b1;
                PH_G:    cap_g_s = 1'b1;
                PH_B:    cap_b_s = 1'b1;
                default: cap_b_s = 1'b0;
            endcase
        end
    end

    // Shadow registers for the pixel being assembled
    always_ff @(posedge VCLK or posedge VRST) begin
        if (VRST) begin
            sync_r   <= sync_idle;
            red_r    <= '0;
            grn_r    <= '0;
            blu_r    <= '0;
            commit_r <= 1'b0;
        end else begin
            if (cap_sync_s) sync_r <= VD_i[3:0];
            if (cap_r_s)    red_r  <= VD_i;
            if (cap_g_s)    grn_r  <= VD_i;
            if (cap_b_s)    blu_r  <= VD_i;
            commit_r <= cap_b_s;
        end
    end

    // Output word and strobe, loaded one edge after blue is sampled
    always_ff @(posedge VCLK or posedge VRST) begin
        if (VRST) begin
            vdata_o       <= {sync_idle, {(3*color_width_i){1'b0}}};
            vdata_valid_o <= 1'b0;
        end else begin
            vdata_valid_o <= commit_r;
            if (commit_r) begin
                vdata_o <= {sync_r, red_r, grn_r, blu_r};
            end
        end
    end

`ifdef N64_VDEMUX_VINFO_EN
    n64_vinfo_ext #(
        .pal_thresh (pal_thresh)
    ) u_vinfo (
        .clk      (VCLK),
        .rst      (VRST),
        .sync_nib (sync_r),
        .commit   (commit_r),
        .vinfo    (vinfo_o),
        .field    (field_o)
    );
`else
    // Threshold only matters when the frame analysis is compiled in
    logic unused_pal_thresh_s;
    assign unused_pal_thresh_s = ^pal_thresh;
    assign vinfo_o = 2'b00;
    assign field_o = 1'b0;
`endif

endmodule

// File: tb/tb_n64_vdemux.sv
// Scoreboard bench for n64_vdemux: expected words and video info are queued
// as pixels are driven and compared at each strobe.
module tb_n64_vdemux;
    import n64adv_vparams::*;

    localparam int cw = color_width_i;
    localparam int vw = vdata_width;
`ifdef N64_VDEMUX_VINFO_EN
    localparam bit vinfo_en = 1'b1;
`else
    localparam bit vinfo_en = 1'b0;
`endif
    localparam logic [vw-1:0] vdata_rst = {4'hF, {(3*cw){1'b0}}};

    logic          VCLK = 1'b0;
    logic          VRST = 1'b1;
    logic          nVDSYNC = 1'b1;
    logic [cw-1:0] VD_i = '0;
    logic          vdata_valid_o;
    logic [vw-1:0] vdata_o;
    logic [1:0]    vinfo_o;
    logic          field_o;

    n64_vdemux #(
        .color_width_i (cw),
        .pal_thresh    (10'd288)
    ) dut (
        .VCLK          (VCLK),
        .VRST          (VRST),
        .nVDSYNC       (nVDSYNC),
        .VD_i          (VD_i),
        .vdata_valid_o (vdata_valid_o),
        .vdata_o       (vdata_o),
        .vinfo_o       (vinfo_o),
        .field_o       (field_o)
    );

    always #5 VCLK = ~VCLK;

    typedef struct packed {
        logic [vw-1:0] vd;
        logic [1:0]    vinfo;
        logic          field;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_pass = 0;
    int         strobe_cnt = 0;
    int         cnt0;

    logic [3:0] m_prev;
    logic [9:0] m_line;
    logic       m_plsb, m_pal, m_i480, m_field;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_prev  = 4'hF;
        m_line  = 10'd0;
        m_plsb  = 1'b0;
        m_pal   = 1'b0;
        m_i480  = 1'b0;
        m_field = 1'b0;
        exp_q.delete();
    endtask

    // Reference behaviour of one committed pixel
    task automatic push_model(input logic [3:0] s, input logic [cw-1:0] r,
                              input logic [cw-1:0] g, input logic [cw-1:0] b);
        exp_t e;
        logic hs_fall, vs_fall;
        hs_fall = m_prev[1] && !s[1];
        vs_fall = m_prev[3] && !s[3];
        if (vs_fall) begin
            m_pal   = (m_line > 10'd288);
            m_i480  = (m_line[0] != m_plsb);
            m_plsb  = m_line[0];
            m_field = !m_field;
            m_line  = hs_fall ? 10'd1 : 10'd0;
        end else if (hs_fall && m_line < 10'd1023) begin
            m_line = m_line + 10'd1;
        end
        m_prev  = s;
        e.vd    = {s, r, g, b};
        e.vinfo = vinfo_en ? {m_pal, m_i480} : 2'b00;
        e.field = vinfo_en ? m_field : 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic drv(input logic nvd, input logic [cw-1:0] vd);
        @(negedge VCLK);
        nVDSYNC = nvd;
        VD_i    = vd;
    endtask

    task automatic send_pixel(input logic [3:0] s, input logic [cw-1:0] r,
                              input logic [cw-1:0] g, input logic [cw-1:0] b);
        drv(1'b0, {{(cw-4){1'b0}}, s});
        drv(1'b1, r);
        drv(1'b1, g);
        drv(1'b1, b);
        push_model(s, r, g, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b1, cw'($urandom));
    endtask

    task automatic do_reset();
        @(negedge VCLK);
        VRST    = 1'b1;
        nVDSYNC = 1'b1;
        model_reset();
        @(negedge VCLK);
        VRST = 1'b0;
    endtask

    task automatic line();
        send_pixel(4'hC, cw'($urandom), cw'($urandom), cw'($urandom));
        send_pixel(4'hF, cw'($urandom), cw'($urandom), cw'($urandom));
    endtask

    task automatic vsync();
        send_pixel(4'h7, cw'($urandom), cw'($urandom), cw'($urandom));
    endtask

    task automatic frame(input int n);
        vsync();
        for (int i = 0; i < n; i++) line();
    endtask

    task automatic drain();
        for (int i = 0; i < 16; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge VCLK);
        end
        #2;
        check_val("drain", exp_q.size(), 0);
    endtask

    // Strobe monitor: every strobe must match the oldest queued expectation
    always @(posedge VCLK) begin
        #1;
        if (vdata_valid_o) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                check_val("spurious_strobe", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("vdata", vdata_o, mon_e.vd);
                check_val("vinfo", vinfo_o, mon_e.vinfo);
                check_val("field", field_o, mon_e.field);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge VCLK);
        check_val("rst_vdata", vdata_o, vdata_rst);
        check_val("rst_valid", vdata_valid_o, 0);
        check_val("rst_vinfo", vinfo_o, 0);
        check_val("rst_field", field_o, 0);
        VRST = 1'b0;

        // nominal pixel and latency
        drv(1'b0, 7'h0F);
        drv(1'b1, 7'h11);
        drv(1'b1, 7'h22);
        drv(1'b1, 7'h33);
        push_model(4'hF, 7'h11, 7'h22, 7'h33);
        @(posedge VCLK); #1;
        check_val("lat_b_edge", vdata_valid_o, 0);
        @(posedge VCLK); #1;
        check_val("lat_strobe", vdata_valid_o, 1);
        check_val("nominal_word", vdata_o, {4'hF, 7'h11, 7'h22, 7'h33});
        @(negedge VCLK);
        cnt0 = strobe_cnt;
        idle(8);
        check_val("idle_no_strobe", strobe_cnt - cnt0, 0);

        // aborted pixels after R and after G
        cnt0 = strobe_cnt;
        drv(1'b0, 7'h0F);
        drv(1'b1, 7'h55);
        send_pixel(4'hF, 7'h01, 7'h02, 7'h03);
        idle(3);
        check_val("abort_r_one_strobe", strobe_cnt - cnt0, 1);
        cnt0 = strobe_cnt;
        drv(1'b0, 7'h0F);
        drv(1'b1, 7'h66);
        drv(1'b1, 7'h77);
        send_pixel(4'hF, 7'h04, 7'h05, 7'h06);
        idle(3);
        check_val("abort_g_one_strobe", strobe_cnt - cnt0, 1);
        drain();

        // NTSC 240p
        do_reset();
        for (int f = 0; f < 3; f++) frame(263);
        vsync();
        idle(3);
        drain();
        check_val("ntsc240p_vinfo", vinfo_o, 2'b00);

        // NTSC 480i
        do_reset();
        frame(263);
        frame(262);
        frame(263);
        vsync();
        idle(3);
        drain();
        check_val("ntsc480i_vinfo", vinfo_o, vinfo_en ? 2'b01 : 2'b00);

        // PAL
        do_reset();
        frame(313);
        frame(313);
        vsync();
        idle(3);
        drain();
        check_val("pal_vinfo", vinfo_o, vinfo_en ? 2'b10 : 2'b00);
        check_val("pal_field", field_o, vinfo_en ? 1 : 0);

        // reset between G and B
        send_pixel(4'hF, 7'h2A, 7'h2B, 7'h2C);
        idle(2);
        drain();
        drv(1'b0, 7'h0F);
        drv(1'b1, 7'h3A);
        drv(1'b1, 7'h3B);
        @(negedge VCLK);
        VRST = 1'b1;
        #1;
        check_val("midrst_vdata", vdata_o, vdata_rst);
        check_val("midrst_valid", vdata_valid_o, 0);
        check_val("midrst_vinfo", vinfo_o, 0);
        check_val("midrst_field", field_o, 0);
        model_reset();
        #1;
        VRST = 1'b0;
        cnt0 = strobe_cnt;
        drv(1'b1, 7'h3C);
        idle(6);
        check_val("midrst_no_strobe", strobe_cnt - cnt0, 0);
        send_pixel(4'hF, 7'h41, 7'h42, 7'h43);
        idle(3);
        check_val("midrst_recover", strobe_cnt - cnt0, 1);
        drain();

        // line counter saturation
        do_reset();
        vsync();
        for (int i = 0; i < 1100; i++) line();
        vsync();
        idle(3);
        drain();
        check_val("sat_vinfo", vinfo_o, vinfo_en ? 2'b11 : 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/n64_vdemux.md
# n64_vdemux

Front-end capture stage between the N64 video bus pins (VCLK, nVDSYNC, VD_i) and the picture processing unit. Demultiplexes the 4-phase VD stream into one parallel word per pixel: sync nibble, R, G, B. Also derives per-frame video info (PAL/NTSC, 240p/480i) by counting lines between vertical syncs.

## Interface
- `color_width_i`, default 7: VD bus and per-channel width.
- `pal_thresh`, default 10'd288: lines-per-field boundary between NTSC and PAL.
- `VCLK` in, 1 bit: N64 video clock. All logic is on the rising edge.
- `VRST` in, 1 bit: asynchronous, active-high reset.
- `nVDSYNC` in, 1 bit: low marks the sync phase of VD_i.
- `VD_i` in, 7 bits: multiplexed N64 video data.
- `vdata_valid_o` out, 1 bit: one-cycle strobe; `vdata_o` is updated in the same cycle.
- `vdata_o` out, 25 bits: {nVSYNC, nCLAMP, nHSYNC, nCSYNC, R[6:0], G[6:0], B[6:0]}.
- `vinfo_o` out, 2 bits: {pal, n64_480i}.
- `field_o` out, 1 bit: field toggle, updated at each vertical sync.

## Operation
- 2-bit phase counter `ph`.
  - nVDSYNC=0 at an edge: capture sync bits VD_i[3:0] into a shadow register and set ph=1. This applies regardless of the current ph.
  - nVDSYNC=1 and ph=1: capture R, set ph=2.
  - nVDSYNC=1 and ph=2: capture G, set ph=3.
  - nVDSYNC=1 and ph=3: capture B, set ph=0, and set the commit flag.
  - nVDSYNC=1 and ph=0: idle. Data is ignored until the next sync phase.
- Commit: on the edge after B is sampled, load `vdata_o` with the shadow sync, R, G and B values, and pulse `vdata_valid_o` high for 1 cycle.
- Aborted pixel: if nVDSYNC goes low while ph is 1, 2 or 3, the partial pixel is discarded. The phase restarts and no strobe is issued.
- Sync edges are evaluated only on committed pixels, by comparing against the previously committed sync nibble.
- Line counter: 10 bits, increments on each nHSYNC falling edge and saturates at 1023.
- On each nVSYNC falling edge:
  - pal = (line_cnt > pal_thresh).
  - n64_480i = (line_cnt[0] != prev_line_lsb).
  - prev_line_lsb <= line_cnt[0].
  - field_o toggles.
  - line_cnt restarts at 0. If an hsync edge falls in the same pixel, line_cnt is set to 1.
- `vinfo_o` changes only at nVSYNC falling edges. It is stable for the whole frame.

## Timing
- Reset values:
  - `vdata_o` sync nibble = 4'hF (inactive). Colours = 0.
  - `vdata_valid_o`=0, `vinfo_o`=2'b00, `field_o`=0.
  - ph=0, line_cnt=0, prev_line_lsb=0.
- Latency: the sync phase sample to `vdata_valid_o` is 4 VCLK edges. The B sample to the strobe is 1 edge.
- Strobe rate: at most 1 per 4 VCLK cycles. There is no backpressure; the consumer must accept every strobe.
- `vinfo_o` and `field_o` update in the same cycle as the strobe of the pixel carrying the nVSYNC falling edge.
- Reset asserted mid-pixel: all state clears at once. The first valid strobe after release requires a full sync, R, G, B sequence.

## Configuration
- `N64_VDEMUX_VINFO_EN` defined: the line counter, PAL/480i detection and field toggle are compiled in.
- Not defined: `vinfo_o`=2'b00 and `field_o`=0 constantly. The line-counting logic is absent. Demux behaviour is unchanged.

## Structure
- Shared package `n64adv_vparams`:
  - `color_width_i`.
  - `vdata_width` = 4+3*color_width_i.
  - Bit-index constants for the sync nibble (`vdata_vs`, `vdata_clmp`, `vdata_hs`, `vdata_cs`).
  - `pal_thresh` default.
  - Type for the phase counter.
- Sub-module `n64_vinfo_ext`:
  - Takes the committed sync nibble and the valid strobe.
  - Holds the edge detectors, line counter and vinfo/field registers.
  - Instantiated only under `N64_VDEMUX_VINFO_EN`.

## Test plan
- Nominal pixel: nVDSYNC low with VD=7'h0F, then VD=7'h11, 7'h22, 7'h33 → after 4 edges, one strobe with `vdata_o`={4'hF,7'h11,7'h22,7'h33}. No further strobe while nVDSYNC stays high.
- Abort: sync, R=7'h55, then nVDSYNC low early, then full pixel R/G/B=7'h01/02/03 → exactly one strobe, carrying 01/02/03. 7'h55 never appears.
- NTSC 240p: 3 frames of 263 hsync edges each → after frame 2, `vinfo_o`=2'b00. `field_o` toggles each vsync.
- NTSC 480i: alternating fields of 262/263 lines → `vinfo_o`=2'b01 from the second vsync on.
- PAL: 313-line fields → pal=1. Line counter saturation: 1100 hsyncs with no vsync → count holds at 1023, then pal=1 at the next vsync.
- Reset: VRST pulsed between G and B → outputs return to reset values at once, no strobe. With the macro undefined, `vinfo_o` and `field_o` stay 0 through the PAL stimulus.
